training_sample_sequencer: RTL and testbench
============================================

Name: training_sample_sequencer

Overview:
Source end of the perceptron trainer's sample interface. Buffers up to DEPTH labelled training samples (x1, x2, target) in signed Q15.16, then replays them in order for EPOCHS passes. Each sample is presented on registered outputs with a valid level so the trainer's train_x1_in/train_x2_in/train_out_in/valid_i inputs can be wired directly. Sits between the host/config loader and neuron_trainer.

Parameters:
SIGN, 1, sign bits of fixed-point word
Q_M, 15, integer bits
Q_N, 16, fraction bits (word W = SIGN+Q_M+Q_N = 32)
DEPTH, 4, sample buffer entries (power of 2, >=2)
EPOCHS, 5, passes over the buffer per start
HOLD_CYCLES, 4, cycles each sample is held with valid_o high (>=1)

Ports:
clk_i  in  1  clock, all logic on rising edge
reset_i  in  1  synchronous, active-high reset
wr_en_i  in  1  buffer write strobe
wr_addr_i  in  $clog2(DEPTH)  buffer write index
wr_x1_i  in  W  sample input 1
wr_x2_i  in  W  sample input 2
wr_out_i  in  W  sample target
num_samples_i  in  $clog2(DEPTH)+1  samples per epoch, sampled on start
start_i  in  1  begin streaming
train_x1_o  out  W  to trainer train_x1_in
train_x2_o  out  W  to trainer train_x2_in
train_out_o  out  W  to trainer train_out_in
valid_o  out  1  to trainer valid_i
busy_o  out  1  high in STREAM/GAP
done_o  out  1  level, high in DONE
err_o  out  1  one-cycle pulse on rejected start
epoch_o  out  $clog2(EPOCHS+1)  current epoch index
sample_idx_o  out  $clog2(DEPTH)  current sample index

Behaviour:
- Reset (sync, any state): state IDLE; all outputs 0; buffer entries cleared to 0; counters 0. Reset mid-stream aborts immediately, valid_o 0 on the next edge.
- States: IDLE, STREAM, GAP, DONE.
- Writes: accepted only in IDLE or DONE; ignored in STREAM/GAP. A write and a start in the same cycle: the write commits first, so streaming sees the new data.
- IDLE/DONE + start_i: if 1 <= num_samples_i <= DEPTH, latch N, clear counters, clear done_o, go to STREAM; the next edge shows valid_o=1 with sample 0 (1-cycle latency). Otherwise stay in the current state, pulse err_o for 1 cycle, done_o unchanged.
- STREAM: outputs show buffer[idx]; valid_o=1 for exactly HOLD_CYCLES cycles (hold counter).
  - At the end of a hold, if this was not the last sample of the last epoch, go to GAP.
  - Otherwise go to DONE.
- GAP: one cycle, valid_o=0, data outputs keep their last value. Advance idx; when idx wraps at N-1 to 0, increment epoch. Return to STREAM.
- DONE: valid_o=0, busy_o=0, done_o=1, data outputs hold the last sample.
- start_i during STREAM/GAP is ignored (no err_o).
- Total cycles from first valid_o to done_o = EPOCHS*N*(HOLD_CYCLES+1) - 1.
- Data is passed through unmodified; no arithmetic on samples; widths are exact.

Decomposition:
- Package nn_fixed_pkg:
  - localparams SIGN/Q_M/Q_N/W
  - typedef fixed_t (logic signed [W-1:0])
  - typedef struct sample_t {x1, x2, target}
  - state enum seq_state_t
  - constant FIXED_ONE = 32'h0001_0000
- One sub-module: sample_buffer, a DEPTH x sample_t register file with sync write, async read, and sync clear on reset.

Test Plan:
- Reset, write entry0={1.0,1.0,1.0} (32'h00010000 each), num_samples=1, start -> valid_o high 4 cycles, low 1 cycle, repeated 5 times. done_o rises 24 cycles after first valid_o, and data equals 32'h00010000 throughout.
- Write 2 samples ({1.0,0,1.0},{0,1.0,0}), N=2 -> order per epoch is 0,1. epoch_o steps 0..4, sample_idx_o alternates, done_o 49 cycles after first valid_o.
- start with num_samples_i=0 and with 5 -> err_o single-cycle pulse, state stays IDLE, valid_o stays 0.
- Write to addr 0 with 32'hFFFF0000 (-1.0) during STREAM -> ignored; the replayed value is unchanged. In the same cycle as a start from DONE, the write is visible on the first valid sample.
- reset_i asserted in the middle of epoch 2 -> next edge valid_o=0, busy_o=0, epoch_o=0, buffer reads 0. A new start with N=1 streams zeros.
- start_i pulsed while busy -> no restart, no err_o, total cycle count unchanged.

Source files
------------

// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point types for the perceptron datapath: signed Q15.16 words,
// labelled training samples and the sample sequencer's state encoding.
package nn_fixed_pkg;
    localparam int SIGN = 1;
    localparam int Q_M  = 15;
    localparam int Q_N  = 16;
    localparam int W    = SIGN + Q_M + Q_N;

    typedef logic signed [W-1:0] fixed_t;

    typedef struct packed {
        fixed_t x1;
        fixed_t x2;
        fixed_t target;
    } sample_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

    localparam fixed_t FIXED_ONE = 32'h0001_0000;
endpackage

// File: rtl/sample_buffer.sv
// DEPTH-entry training sample register file: synchronous write, combinational
// read, every entry cleared while reset is held.
module sample_buffer
    import nn_fixed_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  sample_t       wdata_i,
    input  logic [AW-1:0] raddr_i,
    output sample_t       rdata_o
);
    sample_t mem_r [DEPTH];

    // Entry storage with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_r[raddr_i];
endmodule

// File: rtl/training_sample_sequencer.sv
// Buffers labelled samples and replays them EPOCHS times to the neuron trainer,
// each sample held valid for HOLD_CYCLES cycles followed by a one-cycle gap.
module training_sample_sequencer
    import nn_fixed_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int EPOCHS      = 5,
    parameter int HOLD_CYCLES = 4,
    localparam int IW = $clog2(DEPTH),
    localparam int NW = IW + 1,
    localparam int EW = $clog2(EPOCHS + 1),
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_x1_i,
    input  logic [W-1:0]  wr_x2_i,
    input  logic [W-1:0]  wr_out_i,
    input  logic [NW-1:0] num_samples_i,
    input  logic          start_i,
    output logic [W-1:0]  train_x1_o,
    output logic [W-1:0]  train_x2_o,
    output logic [W-1:0]  train_out_o,
    output logic          valid_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [EW-1:0] epoch_o,
    output logic [IW-1:0] sample_idx_o
);
    seq_state_t    state_r, state_s;
    logic [IW-1:0] idx_r, idx_s, idx_adv_s, rd_addr_s;
    logic [EW-1:0] epoch_r, epoch_s;
    logic [HW-1:0] hold_r, hold_s;
    logic [NW-1:0] n_r, n_s;
    sample_t       data_r, data_s, wr_sample_s, rd_sample_s, load_s;
    logic          valid_r, valid_s, busy_r, busy_s, done_r, done_s, err_r, err_s;
    logic          wr_ok_s, start_ok_s, idx_last_s, epoch_last_s, hold_last_s;

    assign wr_ok_s      = wr_en_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign wr_sample_s  = {wr_x1_i, wr_x2_i, wr_out_i};
    assign start_ok_s   = (num_samples_i != '0) && (num_samples_i <= NW'(DEPTH));
    assign idx_last_s   = ({1'b0, idx_r} == (n_r - NW'(1)));
    assign epoch_last_s = (epoch_r == EW'(EPOCHS - 1));
    assign hold_last_s  = (hold_r == HW'(HOLD_CYCLES - 1));
    assign idx_adv_s    = idx_last_s ? '0 : (idx_r + IW'(1));
    assign rd_addr_s    = (state_r == ST_GAP) ? idx_adv_s : '0;
    // A write landing in the same cycle as a start must be seen by sample 0.
    assign load_s       = (wr_ok_s && (wr_addr_i == rd_addr_s)) ? wr_sample_s : rd_sample_s;

    sample_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (wr_ok_s),
        .waddr_i (wr_addr_i),
        .wdata_i (wr_sample_s),
        .raddr_i (rd_addr_s),
        .rdata_o (rd_sample_s)
    );

    // Next-state and next-output computation.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        epoch_s = epoch_r;
        hold_s  = hold_r;
        n_s     = n_r;
        data_s  = data_r;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = done_r;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i && start_ok_s) begin
                    n_s     = num_samples_i;
                    idx_s   = '0;
                    epoch_s = '0;
                    hold_s  = '0;
                    done_s  = 1'b0;
                    data_s  = load_s;
                    valid_s = 1'b1;
                    busy_s  = 1'b1;
                    state_s = ST_STREAM;
                end else if (start_i) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
            end
            ST_STREAM: begin
                if (!hold_last_s) begin
                    hold_s  = hold_r + HW'(1);
                    valid_s = 1'b1;
                    busy_s  = 1'b1;
                end else if (idx_last_s && epoch_last_s) begin
                    hold_s  = '0;
                    done_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    hold_s  = '0;
                    busy_s  = 1'b1;
                    state_s = ST_GAP;
                end
            end
            ST_GAP: begin
                idx_s   = idx_adv_s;
                data_s  = load_s;
                valid_s = 1'b1;
                busy_s  = 1'b1;
                state_s = ST_STREAM;
                if (idx_last_s) begin
                    epoch_s = epoch_r + EW'(1);
                end else begin
                    epoch_s = epoch_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            epoch_r <= '0;
            hold_r  <= '0;
            n_r     <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            epoch_r <= epoch_s;
            hold_r  <= hold_s;
            n_r     <= n_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign train_x1_o   = data_r.x1;
    assign train_x2_o   = data_r.x2;
    assign train_out_o  = data_r.target;
    assign valid_o      = valid_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;
    assign epoch_o      = epoch_r;
    assign sample_idx_o = idx_r;
endmodule

// File: tb/tb_training_sample_sequencer.sv
// Self-checking bench for training_sample_sequencer: idle-state vector table,
// directed streaming sequences and randomized runs against a slot-arithmetic model.
module tb_training_sample_sequencer;
    import nn_fixed_pkg::*;

    localparam int DEPTH  = 4;
    localparam int EPOCHS = 5;
    localparam int HOLD   = 4;

    logic        clk = 1'b0;
    logic        reset_i, wr_en_i, start_i;
    logic [1:0]  wr_addr_i;
    logic [31:0] wr_x1_i, wr_x2_i, wr_out_i;
    logic [2:0]  num_samples_i;
    logic [31:0] train_x1_o, train_x2_o, train_out_o;
    logic        valid_o, busy_o, done_o, err_o;
    logic [2:0]  epoch_o;
    logic [1:0]  sample_idx_o;

    logic [31:0] bx1 [DEPTH];
    logic [31:0] bx2 [DEPTH];
    logic [31:0] bout[DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       start;
        logic [2:0] n;
        logic       err;
        logic       valid;
        logic       busy;
    } vec_t;
    vec_t tbl[6];

    training_sample_sequencer #(.DEPTH(DEPTH), .EPOCHS(EPOCHS), .HOLD_CYCLES(HOLD)) dut (
        .clk_i(clk), .reset_i(reset_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_x1_i(wr_x1_i), .wr_x2_i(wr_x2_i), .wr_out_i(wr_out_i),
        .num_samples_i(num_samples_i), .start_i(start_i),
        .train_x1_o(train_x1_o), .train_x2_o(train_x2_o), .train_out_o(train_out_o),
        .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .epoch_o(epoch_o), .sample_idx_o(sample_idx_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic b, input logic d,
                              input logic e, input int ep, input int ix,
                              input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] o);
        chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
        chk({tag, ".busy"},  {31'd0, busy_o},  {31'd0, b});
        chk({tag, ".done"},  {31'd0, done_o},  {31'd0, d});
        chk({tag, ".err"},   {31'd0, err_o},   {31'd0, e});
        chk({tag, ".epoch"}, {29'd0, epoch_o}, 32'(ep));
        chk({tag, ".idx"},   {30'd0, sample_idx_o}, 32'(ix));
        chk({tag, ".x1"},    train_x1_o,  x1);
        chk({tag, ".x2"},    train_x2_o,  x2);
        chk({tag, ".out"},   train_out_o, o);
    endtask

    task automatic do_write(input int a, input logic [31:0] x1, input logic [31:0] x2,
                            input logic [31:0] o);
        wr_en_i = 1'b1; wr_addr_i = 2'(a);
        wr_x1_i = x1; wr_x2_i = x2; wr_out_i = o;
        bx1[a] = x1; bx2[a] = x2; bout[a] = o;
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            bx1[i] = 32'd0; bx2[i] = 32'd0; bout[i] = 32'd0;
        end
    endtask

    // Starts a run of n samples and checks every cycle until done (or stop_k).
    // Expected behaviour derives only from the cycle offset k: each slot is
    // HOLD valid cycles plus one gap, and the final gap slot becomes done.
    task automatic start_and_check(input int n, input bit poke, input int stop_k);
        int total;
        total = EPOCHS * n * (HOLD + 1);
        num_samples_i = 3'(n);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wr_en_i = 1'b0;
        for (int k = 0; k < total; k++) begin
            int  slot, phase, s, ep;
            bit  last;
            slot  = k / (HOLD + 1);
            phase = k % (HOLD + 1);
            s     = slot % n;
            ep    = slot / n;
            last  = (k == total - 1);
            check_outs($sformatf("n%0d.k%0d", n, k), !last && (phase < HOLD), !last, last,
                       1'b0, ep, s, bx1[s], bx2[s], bout[s]);
            if (k == stop_k) return;
            if (poke && !last) begin
                wr_en_i = 1'($urandom); wr_addr_i = 2'($urandom);
                wr_x1_i = $urandom; wr_x2_i = $urandom; wr_out_i = $urandom;
                start_i = 1'($urandom); num_samples_i = 3'($urandom);
            end else begin
                wr_en_i = 1'b0; start_i = 1'b0;
            end
            tick();
        end
        check_outs($sformatf("n%0d.hold_done", n), 1'b0, 1'b0, 1'b1, 1'b0, EPOCHS - 1, n - 1,
                   bx1[n-1], bx2[n-1], bout[n-1]);
    endtask

    initial begin
        reset_i = 1'b1; wr_en_i = 1'b0; start_i = 1'b0; wr_addr_i = 2'd0;
        wr_x1_i = 32'd0; wr_x2_i = 32'd0; wr_out_i = 32'd0; num_samples_i = 3'd0;
        clear_model();
        tbl[0] = '{start: 1'b1, n: 3'd0, err: 1'b1, valid: 1'b0, busy: 1'b0};
        tbl[1] = '{start: 1'b0, n: 3'd0, err: 1'b0, valid: 1'b0, busy: 1'b0};
        tbl[2] = '{start: 1'b1, n: 3'd5, err: 1'b1, valid: 1'b0, busy: 1'b0};
        tbl[3] = '{start: 1'b1, n: 3'd7, err: 1'b1, valid: 1'b0, busy: 1'b0};
        tbl[4] = '{start: 1'b0, n: 3'd3, err: 1'b0, valid: 1'b0, busy: 1'b0};
        tbl[5] = '{start: 1'b1, n: 3'd6, err: 1'b1, valid: 1'b0, busy: 1'b0};

        tick(); tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0, 32'd0, 32'd0);
        reset_i = 1'b0;

        // Rejected starts from IDLE.
        for (int i = 0; i < 6; i++) begin
            start_i = tbl[i].start; num_samples_i = tbl[i].n;
            tick();
            check_outs($sformatf("tbl%0d", i), tbl[i].valid, tbl[i].busy, 1'b0, tbl[i].err,
                       0, 0, 32'd0, 32'd0, 32'd0);
        end
        start_i = 1'b0;

        do_write(0, FIXED_ONE, FIXED_ONE, FIXED_ONE);
        start_and_check(1, 1'b0, -1);

        do_write(0, FIXED_ONE, 32'd0, FIXED_ONE);
        do_write(1, 32'd0, FIXED_ONE, 32'd0);
        start_and_check(2, 1'b0, -1);

        // Rejected start from DONE keeps done_o.
        num_samples_i = 3'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_outs("done_rej", 1'b0, 1'b0, 1'b1, 1'b1, EPOCHS - 1, 1, bx1[1], bx2[1], bout[1]);
        tick();
        check_outs("done_rej2", 1'b0, 1'b0, 1'b1, 1'b0, EPOCHS - 1, 1, bx1[1], bx2[1], bout[1]);

        // Write committed in the start cycle; writes/starts while busy are ignored.
        wr_en_i = 1'b1; wr_addr_i = 2'd0;
        wr_x1_i = 32'hFFFF0000; wr_x2_i = 32'hFFFF0000; wr_out_i = 32'hFFFF0000;
        bx1[0] = 32'hFFFF0000; bx2[0] = 32'hFFFF0000; bout[0] = 32'hFFFF0000;
        start_and_check(1, 1'b1, -1);
        start_and_check(2, 1'b1, -1);

        // Reset in the middle of epoch 2 aborts and clears the buffer.
        start_and_check(2, 1'b0, 23);
        chk("pre_reset.epoch", {29'd0, epoch_o}, 32'd2);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        clear_model();
        check_outs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0, 32'd0, 32'd0);
        start_and_check(1, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int j = 0; j < nw; j++) begin
                do_write($urandom_range(0, DEPTH - 1), $urandom, $urandom, $urandom);
            end
            start_and_check($urandom_range(1, DEPTH), 1'b1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
